// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the router input path: widths, flit type
// encoding and the bit positions of the flit_req bundle.
package noc_flit_pkg;

    localparam int FLIT_W     = 34;
    localparam int REQ_W      = 37;
    localparam int NUM_VC_DEF = 3;

    localparam int TYPE_HI   = 33;
    localparam int TYPE_LO   = 32;
    localparam int ROUTE_HI  = 31;
    localparam int ROUTE_LO  = 30;
    localparam int VC_HI     = 2;
    localparam int VC_LO     = 1;
    localparam int VALID_BIT = 0;

    typedef enum logic [1:0] {
        FT_HEAD = 2'b00,
        FT_BODY = 2'b01,
        FT_TAIL = 2'b10,
        FT_RSVD = 2'b11
    } flit_type_e;

    // The reserved encoding closes a packet exactly like a TAIL.
    function automatic logic closes_pkt(input flit_type_e t);
        return (t == FT_TAIL) || (t == FT_RSVD);
    endfunction

endpackage

// File: rtl/input_vc_buffer_if.sv
// Link-side and router-side signals of input_vc_buffer; master drives the
// link flit and the downstream ready, slave is the buffer itself.
interface input_vc_buffer_if
    import noc_flit_pkg::*;
#(
    parameter int NUM_VC = NUM_VC_DEF,
    parameter int FLIT_W = noc_flit_pkg::FLIT_W
);
    logic              fin_valid_i;
    logic [1:0]        fin_vc_i;
    logic [FLIT_W-1:0] fin_flit_i;
    logic [NUM_VC-1:0] fin_ready_o;
    logic [FLIT_W+2:0] flit_req_o;
    logic              fout_ready_i;
    logic [NUM_VC-1:0] vc_empty_o;

    modport master (
        output fin_valid_i, fin_vc_i, fin_flit_i, fout_ready_i,
        input  fin_ready_o, flit_req_o, vc_empty_o
    );

    modport slave (
        input  fin_valid_i, fin_vc_i, fin_flit_i, fout_ready_i,
        output fin_ready_o, flit_req_o, vc_empty_o
    );
endinterface

// File: rtl/vc_fifo.sv
// Single-VC synchronous FIFO with async reset; a write while full is dropped
// even when a read happens in the same cycle.
module vc_fifo
    import noc_flit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 34,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an empty count hides stale entries.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/input_vc_buffer.sv
// Per-VC input buffer with round-robin VC pick and wormhole lock.
// Optional zero-latency bypass into an empty selected VC: INPUT_VC_BUF_BYPASS_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no lock; present first non-empty VC after rr_ptr
//  ST_STALL | candidate frozen in sel_vc until downstream takes it
//  ST_PKT   | packet in flight on sel_vc; only that VC is served
module input_vc_buffer
    import noc_flit_pkg::*;
#(
    parameter int NUM_VC     = NUM_VC_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int FLIT_W     = noc_flit_pkg::FLIT_W
) (
    input logic              clk,
    input logic              arst,
    input_vc_buffer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_PKT   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        rr_ptr;
    logic [1:0]        sel_vc;

    logic [NUM_VC-1:0] wr_en;
    logic [NUM_VC-1:0] rd_en;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] byp_vec;
    logic [NUM_VC-1:0] nonempty_eff;
    logic [FLIT_W-1:0] head [NUM_VC];
    logic [CW-1:0]     count [NUM_VC];

    logic              vc_ok;
    logic              cand_found;
    logic [1:0]        cand_vc;
    logic              out_valid;
    logic [1:0]        out_vc;
    logic              out_byp;
    logic [FLIT_W-1:0] out_flit;
    flit_type_e        out_type;
    logic              xfer;
    logic              byp_take;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (FLIT_W)
        ) u_fifo (
            .clk     (clk),
            .arst    (arst),
            .wr_en   (wr_en[v]),
            .wr_data (bus.fin_flit_i),
            .rd_en   (rd_en[v]),
            .rd_data (head[v]),
            .count   (count[v]),
            .empty   (empty[v])
        );
        assign full[v] = (count[v] == CW'(FIFO_DEPTH));
    end

    assign vc_ok = bus.fin_valid_i && (32'(bus.fin_vc_i) < NUM_VC);

`ifdef INPUT_VC_BUF_BYPASS_EN
    always_comb begin
        byp_vec = '0;
        for (int v = 0; v < NUM_VC; v++)
            byp_vec[v] = vc_ok && (bus.fin_vc_i == 2'(v)) && empty[v];
    end
    assign out_byp  = byp_vec[out_vc];
    assign out_flit = out_byp ? bus.fin_flit_i : head[out_vc];
`else
    assign byp_vec  = '0;
    assign out_byp  = 1'b0;
    assign out_flit = head[out_vc];
`endif

    assign nonempty_eff = ~empty | byp_vec;

    // Scan from farthest to nearest so the first hit after rr_ptr wins.
    always_comb begin
        cand_found = 1'b0;
        cand_vc    = 2'd0;
        for (int k = NUM_VC; k >= 1; k--) begin
            if (nonempty_eff[(int'(rr_ptr) + k) % NUM_VC]) begin
                cand_found = 1'b1;
                cand_vc    = 2'((int'(rr_ptr) + k) % NUM_VC);
            end
        end
    end

    always_comb begin
        out_vc    = sel_vc;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                out_vc    = cand_vc;
                out_valid = cand_found;
            end
            ST_STALL: out_valid = !empty[sel_vc];
            ST_PKT:   out_valid = nonempty_eff[sel_vc];
            default:  out_valid = 1'b0;
        endcase
    end

    assign out_type = flit_type_e'(out_flit[TYPE_HI:TYPE_LO]);
    assign xfer     = out_valid && bus.fout_ready_i;
    assign byp_take = xfer && out_byp;

    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_en[v] = vc_ok && (bus.fin_vc_i == 2'(v)) && !full[v] && !byp_take;
            rd_en[v] = xfer && !out_byp && (out_vc == 2'(v));
        end
    end

    assign bus.flit_req_o  = out_valid ? {out_flit, out_vc, 1'b1} : '0;
    assign bus.fin_ready_o = ~full;
    assign bus.vc_empty_o  = empty;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= ST_IDLE;
            rr_ptr <= 2'd0;
            sel_vc <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cand_found) begin
                        if (!bus.fout_ready_i) begin
                            sel_vc <= cand_vc;
                            state  <= ST_STALL;
                        end else if (out_type == FT_HEAD) begin
                            sel_vc <= cand_vc;
                            state  <= ST_PKT;
                        end else begin
                            rr_ptr <= cand_vc;
                        end
                    end
                end
                ST_STALL: begin
                    if (xfer) begin
                        if (out_type == FT_HEAD) begin
                            state <= ST_PKT;
                        end else begin
                            state  <= ST_IDLE;
                            rr_ptr <= sel_vc;
                        end
                    end
                end
                ST_PKT: begin
                    if (xfer && closes_pkt(out_type)) begin
                        state  <= ST_IDLE;
                        rr_ptr <= sel_vc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_vc_buffer.sv
// Scoreboard bench for input_vc_buffer: per-VC expected queues plus a
// packet-level arbitration model; directed scenarios followed by random traffic.
module tb_input_vc_buffer;
    logic clk;
    logic arst;

    input_vc_buffer_if #(.NUM_VC(3), .FLIT_W(34)) bus ();

    input_vc_buffer #(
        .NUM_VC     (3),
        .FIFO_DEPTH (4),
        .FLIT_W     (34)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [33:0] mq [3][$];
    int          mode;      // 0 free, 1 frozen candidate, 2 packet lock
    int          mvc;
    int          mrr;
    bit          chk_en;
    bit          prev_hold;
    logic [36:0] prev_req;
    bit          rec_en;
    int          emitted [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] mkflit(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    task automatic model_clear();
        for (int v = 0; v < 3; v++) mq[v].delete();
        mode      = 0;
        mvc       = 0;
        mrr       = 0;
        prev_hold = 0;
    endtask

    task automatic drive(input bit v, input int vc, input logic [33:0] f, input bit rdy);
        bus.fin_valid_i  = v;
        bus.fin_vc_i     = 2'(vc);
        bus.fin_flit_i   = f;
        bus.fout_ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT against the model, then apply this cycle's transfer and write.
    always @(negedge clk) begin : mon
        int          evc;
        bit          evalid;
        bit          acc;
        bit          early;
        int          wvc;
        logic [2:0]  exp_rdy;
        logic [2:0]  exp_emp;
        logic [33:0] f;
        if (chk_en && !arst) begin
            wvc = int'(bus.fin_vc_i);
            acc = 0;
            if (bus.fin_valid_i && wvc < 3) acc = (mq[wvc].size() < 4);
            for (int v = 0; v < 3; v++) begin
                exp_rdy[v] = (mq[v].size() < 4);
                exp_emp[v] = (mq[v].size() == 0);
            end
            early = 0;
`ifdef INPUT_VC_BUF_BYPASS_EN
            if (acc && mq[wvc].size() == 0) begin
                early = 1;
                mq[wvc].push_back(bus.fin_flit_i);
            end
`endif
            evc = 0;
            evalid = 0;
            if (mode != 0) begin
                evc = mvc;
                evalid = (mq[mvc].size() > 0);
            end else begin
                for (int k = 3; k >= 1; k--) begin
                    if (mq[(mrr + k) % 3].size() > 0) begin
                        evc = (mrr + k) % 3;
                        evalid = 1;
                    end
                end
            end
            if (evalid) chk("flit_req", bus.flit_req_o, {mq[evc][0], 2'(evc), 1'b1});
            else        chk("flit_req_idle", bus.flit_req_o, 37'd0);
            chk("fin_ready", bus.fin_ready_o, exp_rdy);
            chk("vc_empty", bus.vc_empty_o, exp_emp);
            if (prev_hold) chk("stable", bus.flit_req_o, prev_req);
            prev_hold = evalid && !bus.fout_ready_i;
            prev_req  = bus.flit_req_o;
            if (evalid && bus.fout_ready_i) begin
                f = mq[evc].pop_front();
                if (rec_en) emitted.push_back(evc);
                if (mode == 2) begin
                    if (f[33:32] >= 2'd2) begin
                        mode = 0;
                        mrr  = evc;
                    end
                end else if (f[33:32] == 2'd0) begin
                    mode = 2;
                    mvc  = evc;
                end else begin
                    mode = 0;
                    mrr  = evc;
                end
            end else if (evalid && mode == 0) begin
                mode = 1;
                mvc  = evc;
            end
            if (acc && !early) mq[wvc].push_back(bus.fin_flit_i);
        end
    end

    initial begin
        int rr_exp [6];
        rr_exp = '{1, 1, 2, 2, 0, 0};
        bus.fin_valid_i  = 0;
        bus.fin_vc_i     = 0;
        bus.fin_flit_i   = '0;
        bus.fout_ready_i = 0;
        arst   = 1;
        chk_en = 0;
        rec_en = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.flit_req_o, 37'd0);
        chk("rst_ready", bus.fin_ready_o, 3'b111);
        chk("rst_empty", bus.vc_empty_o, 3'b111);
        arst   = 0;
        chk_en = 1;

        // Single-VC order
        drive(1, 0, mkflit(2'b00, 32'h8000_00A1), 1);
        drive(1, 0, mkflit(2'b01, 32'h0000_00A2), 1);
        drive(1, 0, mkflit(2'b10, 32'h0000_00A3), 1);
        repeat (3) drive(0, 0, '0, 1);
        chk("order_state_idle", dut.state, 2'd0);

        // Wormhole lock with bubbles while VC2 waits
        drive(1, 0, mkflit(2'b00, 32'h4000_00B1), 1);
        drive(1, 2, mkflit(2'b00, 32'hC000_00C1), 1);
        drive(1, 2, mkflit(2'b10, 32'h0000_00C2), 1);
        drive(0, 0, '0, 1);
        drive(1, 0, mkflit(2'b01, 32'h0000_00B2), 1);
        drive(1, 0, mkflit(2'b10, 32'h0000_00B3), 1);
        repeat (5) drive(0, 0, '0, 1);

        // Reset mid-packet on VC1
        drive(1, 1, mkflit(2'b00, 32'h4000_00D1), 1);
        drive(1, 1, mkflit(2'b01, 32'h0000_00D2), 1);
        drive(1, 1, mkflit(2'b01, 32'h0000_00D3), 0);
        drive(1, 1, mkflit(2'b01, 32'h0000_00D4), 0);
        drive(0, 0, '0, 0);
        chk("pre_rst_state_pkt", dut.state, 2'd2);
        arst = 1;
        #1;
        chk("mid_rst_req", bus.flit_req_o, 37'd0);
        chk("mid_rst_ready", bus.fin_ready_o, 3'b111);
        chk("mid_rst_empty", bus.vc_empty_o, 3'b111);
        chk("mid_rst_state", dut.state, 2'd0);
        model_clear();
        @(posedge clk);
        #1;
        arst = 0;

        // Round-robin from rr_ptr = 0
        rec_en = 1;
        emitted.delete();
        drive(1, 1, mkflit(2'b00, 32'h0000_0011), 0);
        drive(1, 1, mkflit(2'b10, 32'h0000_0012), 0);
        drive(1, 2, mkflit(2'b00, 32'h0000_0021), 0);
        drive(1, 2, mkflit(2'b10, 32'h0000_0022), 0);
        drive(1, 0, mkflit(2'b00, 32'h0000_0001), 0);
        drive(1, 0, mkflit(2'b10, 32'h0000_0002), 0);
        repeat (10) drive(0, 0, '0, 1);
        rec_en = 0;
        chk("rr_count", emitted.size(), 6);
        for (int i = 0; i < 6 && i < emitted.size(); i++)
            chk("rr_vc", emitted[i], rr_exp[i]);

        // Full VC1 under backpressure; 5th write dropped
        drive(1, 1, mkflit(2'b00, 32'h0000_0E01), 0);
        drive(1, 1, mkflit(2'b01, 32'h0000_0E02), 0);
        drive(1, 1, mkflit(2'b01, 32'h0000_0E03), 0);
        drive(1, 1, mkflit(2'b10, 32'h0000_0E04), 0);
        chk("full_ready1", bus.fin_ready_o[1], 1'b0);
        drive(1, 1, mkflit(2'b10, 32'h0000_0E05), 0);
        chk("full_keep", bus.fin_ready_o, 3'b101);
        repeat (3) drive(0, 0, '0, 0);
        repeat (8) drive(0, 0, '0, 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [1:0] t;
            r = int'($urandom_range(0, 9));
            t = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
                  mkflit(t, $urandom), ($urandom_range(0, 9) < 6));
        end
        repeat (40) drive(0, 0, '0, 1);

`ifdef INPUT_VC_BUF_BYPASS_EN
        arst = 1;
        #1;
        model_clear();
        @(posedge clk);
        #1;
        arst = 0;
        bus.fin_valid_i  = 1;
        bus.fin_vc_i     = 2'd2;
        bus.fin_flit_i   = mkflit(2'b00, 32'h0000_0B0B);
        bus.fout_ready_i = 1;
        #1;
        chk("byp_same_cycle", bus.flit_req_o, {mkflit(2'b00, 32'h0000_0B0B), 2'd2, 1'b1});
        @(posedge clk);
        #1;
        bus.fin_valid_i = 0;
        #1;
        chk("byp_empty2", bus.vc_empty_o[2], 1'b1);
        repeat (2) drive(0, 0, '0, 1);
`endif

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
